fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction Fetch stage: owns the PC, drives the instruction-memory request/ready handshake and presents {pcPlus4, instruction} to the IF/ID interstage register.
- Handles variable memory latency, pipeline stall via PCWrite, and branch/jump redirects that may arrive while a fetch is outstanding.
- Outputs a NOP (all-zero instruction) whenever no valid fetch is presented, so IF/ID captures a bubble.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.

Ports:
- clock  input  1  stage clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- PCWrite  input  1  1 = advance allowed; 0 = stall (hazard unit; same source as IFIDWrite).
- branchTaken  input  1  branch redirect request.
- branchTarget  input  32  branch target address.
- jump  input  1  jump redirect request.
- jumpTarget  input  32  jump target address.
- imemReady  input  1  memory returns imemData this cycle.
- imemData  input  32  instruction word from memory.
- imemRequest  output  1  fetch request.
- imemAddr  output  32  fetch address; stable while imemRequest=1 and imemReady=0.
- pc  output  32  current PC register.
- pcPlus4  output  32  pc+4, to IF/ID.
- instruction  output  32  fetched word, or 0 when fetchValid=0.
- fetchValid  output  1  instruction/pcPlus4 valid this cycle.

Behaviour:
- States: FETCH, HOLD, DISCARD. Internal registers:
  - holdReg (32): buffered instruction.
  - staleAddr (32): address of an abandoned request.
- Reset (sync): pc=RESET_PC, state=FETCH, holdReg=0, staleAddr=0. During the reset cycle imemRequest=0 and fetchValid=0. Reset mid-fetch abandons the request; memory must accept abandonment.
- Redirect target:
  - branchTaken has priority over jump.
  - Target bits [1:0] are forced to 0.
  - A redirect overrides PCWrite=0 (flush wins over stall).
- FETCH state:
  - imemRequest=1, imemAddr=pc.
  - imemReady=0: fetchValid=0, instruction=0, stay in FETCH.
  - imemReady=1 and PCWrite=1: fetchValid=1, instruction=imemData, pc<=pc+4, stay in FETCH. Zero-wait memory gives one instruction per cycle.
  - imemReady=1 and PCWrite=0: fetchValid=1, instruction=imemData, holdReg<=imemData, go to HOLD, pc unchanged.
- HOLD state:
  - imemRequest=0, fetchValid=1, instruction=holdReg.
  - PCWrite=1: pc<=pc+4, go to FETCH.
- Redirect in FETCH:
  - With imemReady=1: data dropped (fetchValid=0, instruction=0), pc<=target, stay in FETCH.
  - With imemReady=0: staleAddr<=pc, pc<=target, go to DISCARD.
- Redirect in HOLD: holdReg dropped, fetchValid=0, pc<=target, go to FETCH.
- DISCARD state:
  - imemRequest=1, imemAddr=staleAddr, fetchValid=0.
  - On imemReady=1: data dropped, go to FETCH.
  - A further redirect in DISCARD updates pc only.
- Arithmetic: pcPlus4 = pc+4 modulo 2^32; 32'hFFFFFFFC wraps to 0. pcPlus4 always reflects the current pc.
- fetchValid=0 implies instruction=32'h0.
- Latency: address-to-output is combinational on imemReady. PC update lands on the next rising edge.

Test Plan:
- Reset with RESET_PC=32'h400, imemReady tied to 1 -> first cycle after reset imemAddr=0x400; successive imemAddr 0x404, 0x408; pcPlus4 = imemAddr+4; fetchValid=1 every cycle.
- imemReady low for 3 cycles at pc=0x10 -> imemAddr held at 0x10, fetchValid=0, instruction=0; on ready, instruction=imemData and pc becomes 0x14.
- Ready with PCWrite=0 for 2 cycles, imemData=0x8C220004 -> HOLD; instruction stays 0x8C220004 with imemRequest=0; PCWrite=1 -> pc advances exactly once.
- branchTaken (target 0x200) and jump (target 0x300) together while waiting at 0x20 -> DISCARD drives 0x20 until ready with fetchValid=0; next request is 0x200.
- Redirect to 0x103 during HOLD with PCWrite=0 -> fetchValid=0 that cycle; next imemAddr=0x100.
- pc=0xFFFFFFFC -> pcPlus4=0; after the fetch completes, next imemAddr=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the imem request/ready handshake
// and presents {pcPlus4, instruction} to IF/ID. Emits an all-zero NOP whenever
// no valid fetch is presented so IF/ID captures a bubble.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        jump,
  input  logic [31:0] jumpTarget,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic        imemRequest,
  output logic [31:0] imemAddr,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic [31:0] instruction,
  output logic        fetchValid
);

  typedef enum logic [1:0] {
    StFetch,
    StHold,
    StDiscard
  } state_e;

  state_e      r_state, w_state_next;
  logic [31:0] r_pc, w_pc_next;
  logic [31:0] r_hold, w_hold_next;
  logic [31:0] r_stale, w_stale_next;

  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;

  // Branch wins over jump; targets are forced word-aligned.
  assign w_redirect = branchTaken | jump;
  assign w_target   = {(branchTaken ? branchTarget[31:2] : jumpTarget[31:2]), 2'b00};
  assign w_pc_plus4 = r_pc + 32'd4;

  assign pc      = r_pc;
  assign pcPlus4 = w_pc_plus4;

  // State, PC and buffer registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StFetch;
      r_pc    <= RESET_PC;
      r_hold  <= 32'h0;
      r_stale <= 32'h0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_hold  <= w_hold_next;
      r_stale <= w_stale_next;
    end
  end

  // Next-state and handshake/output decode; a redirect always beats a stall.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_hold_next  = r_hold;
    w_stale_next = r_stale;
    imemRequest  = 1'b0;
    imemAddr     = r_pc;
    fetchValid   = 1'b0;
    instruction  = 32'h0;

    unique case (r_state)
      StFetch: begin
        imemRequest = 1'b1;
        if (w_redirect) begin
          // Any returned word is dropped; an outstanding request must be drained.
          w_pc_next = w_target;
          if (!imemReady) begin
            w_stale_next = r_pc;
            w_state_next = StDiscard;
          end
        end else if (imemReady) begin
          fetchValid  = 1'b1;
          instruction = imemData;
          if (PCWrite) begin
            w_pc_next = w_pc_plus4;
          end else begin
            w_hold_next  = imemData;
            w_state_next = StHold;
          end
        end
      end
      StHold: begin
        if (w_redirect) begin
          w_pc_next    = w_target;
          w_state_next = StFetch;
        end else begin
          fetchValid  = 1'b1;
          instruction = r_hold;
          if (PCWrite) begin
            w_pc_next    = w_pc_plus4;
            w_state_next = StFetch;
          end
        end
      end
      StDiscard: begin
        // Keep the abandoned address on the bus until memory answers it.
        imemRequest = 1'b1;
        imemAddr    = r_stale;
        if (w_redirect) begin
          w_pc_next = w_target;
        end
        if (imemReady) begin
          w_state_next = StFetch;
        end
      end
      default: begin
        w_state_next = StFetch;
      end
    endcase

    // Reset cycle: no request, no valid output.
    if (reset) begin
      imemRequest = 1'b0;
      fetchValid  = 1'b0;
      instruction = 32'h0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then random stimulus,
// every cycle compared against a transaction-level reference model.
module tb_fetch_unit;

  localparam logic [31:0] RstPc = 32'h0000_0400;

  logic        clock;
  logic        reset;
  logic        PCWrite;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        jump;
  logic [31:0] jumpTarget;
  logic        imemReady;
  logic [31:0] imemData;
  logic        imemRequest;
  logic [31:0] imemAddr;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [31:0] instruction;
  logic        fetchValid;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: PC, an optional buffered word, an optional abandoned request.
  logic [31:0] m_pc;
  logic [31:0] m_hold;
  logic [31:0] m_stale;
  bit          m_holding;
  bit          m_discarding;

  fetch_unit #(
    .RESET_PC(RstPc)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .PCWrite     (PCWrite),
    .branchTaken (branchTaken),
    .branchTarget(branchTarget),
    .jump        (jump),
    .jumpTarget  (jumpTarget),
    .imemReady   (imemReady),
    .imemData    (imemData),
    .imemRequest (imemRequest),
    .imemAddr    (imemAddr),
    .pc          (pc),
    .pcPlus4     (pcPlus4),
    .instruction (instruction),
    .fetchValid  (fetchValid)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input bit rst, input bit pcw, input bit rdy, input logic [31:0] data,
                       input bit bt, input logic [31:0] btgt, input bit j,
                       input logic [31:0] jtgt);
    reset        = rst;
    PCWrite      = pcw;
    imemReady    = rdy;
    imemData     = data;
    branchTaken  = bt;
    branchTarget = btgt;
    jump         = j;
    jumpTarget   = jtgt;
  endtask

  // Compare outputs mid-cycle, then advance the model on the rising edge.
  task automatic cycle();
    logic        e_req;
    logic        e_fv;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] tgt;
    bit          redir;
    #2;
    redir = branchTaken || jump;
    if (reset) begin
      check_eq("rst_req", {31'b0, imemRequest}, 32'h0);
      check_eq("rst_fv", {31'b0, fetchValid}, 32'h0);
      check_eq("rst_instr", instruction, 32'h0);
    end else begin
      e_addr = m_pc;
      if (m_discarding) begin
        e_req   = 1'b1;
        e_addr  = m_stale;
        e_fv    = 1'b0;
        e_instr = 32'h0;
      end else if (m_holding) begin
        e_req   = 1'b0;
        e_fv    = !redir;
        e_instr = redir ? 32'h0 : m_hold;
      end else begin
        e_req   = 1'b1;
        e_fv    = imemReady && !redir;
        e_instr = e_fv ? imemData : 32'h0;
      end
      check_eq("req", {31'b0, imemRequest}, {31'b0, e_req});
      if (e_req) check_eq("addr", imemAddr, e_addr);
      check_eq("fv", {31'b0, fetchValid}, {31'b0, e_fv});
      check_eq("instr", instruction, e_instr);
      check_eq("pc", pc, m_pc);
      check_eq("pcplus4", pcPlus4, m_pc + 32'd4);
    end
    @(posedge clock);
    tgt = branchTaken ? branchTarget : jumpTarget;
    tgt[1:0] = 2'b00;
    if (reset) begin
      m_pc         = RstPc;
      m_hold       = 32'h0;
      m_stale      = 32'h0;
      m_holding    = 0;
      m_discarding = 0;
    end else if (m_discarding) begin
      if (redir) m_pc = tgt;
      if (imemReady) m_discarding = 0;
    end else if (m_holding) begin
      if (redir) begin
        m_pc      = tgt;
        m_holding = 0;
      end else if (PCWrite) begin
        m_pc      = m_pc + 32'd4;
        m_holding = 0;
      end
    end else if (redir) begin
      if (!imemReady) begin
        m_stale      = m_pc;
        m_discarding = 1;
      end
      m_pc = tgt;
    end else if (imemReady) begin
      if (PCWrite) begin
        m_pc = m_pc + 32'd4;
      end else begin
        m_hold    = imemData;
        m_holding = 1;
      end
    end
    #1;
  endtask

  initial begin
    m_pc         = 32'h0;
    m_hold       = 32'h0;
    m_stale      = 32'h0;
    m_holding    = 0;
    m_discarding = 0;

    // Reset, then zero-wait memory streams one word per cycle.
    drive(1, 1, 1, 32'h1111_1111, 0, 0, 0, 0);
    cycle();
    check_eq("addr_400", imemAddr, 32'h400);
    drive(0, 1, 1, 32'h2222_2222, 0, 0, 0, 0);
    cycle();
    check_eq("addr_404", imemAddr, 32'h404);
    drive(0, 1, 1, 32'h3333_3333, 0, 0, 0, 0);
    cycle();
    check_eq("addr_408", imemAddr, 32'h408);

    // Jump to 0x10 then three wait cycles before ready.
    drive(0, 1, 1, 32'h4444_4444, 0, 0, 1, 32'h10);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 32'hDEAD_0000 + i, 0, 0, 0, 0);
      cycle();
    end
    drive(0, 1, 1, 32'h0123_4567, 0, 0, 0, 0);
    cycle();
    check_eq("pc_14", pc, 32'h14);

    // Stall with a returned word: buffered, then advance exactly once.
    drive(0, 0, 1, 32'h8C22_0004, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 1, 32'h5555_5555, 0, 0, 0, 0);
    cycle();
    drive(0, 1, 0, 32'h6666_6666, 0, 0, 0, 0);
    cycle();
    check_eq("pc_18", pc, 32'h18);

    // Branch and jump together while waiting at 0x20.
    drive(0, 1, 1, 32'h0, 0, 0, 1, 32'h20);
    cycle();
    drive(0, 1, 0, 32'h0, 1, 32'h200, 1, 32'h300);
    cycle();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 32'h7777_7777, 0, 0, 0, 0);
      cycle();
      check_eq("discard_addr", imemAddr, 32'h20);
    end
    drive(0, 1, 1, 32'h8888_8888, 0, 0, 0, 0);
    cycle();
    check_eq("addr_200", imemAddr, 32'h200);

    // Redirect to unaligned 0x103 while holding.
    drive(0, 0, 1, 32'h9999_9999, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 32'h0, 1, 32'h103, 0, 0);
    cycle();
    check_eq("addr_100", imemAddr, 32'h100);

    // PC wrap at the top of the address space.
    drive(0, 1, 1, 32'h0, 0, 0, 1, 32'hFFFF_FFFC);
    cycle();
    check_eq("wrap_p4", pcPlus4, 32'h0);
    drive(0, 1, 1, 32'hAAAA_AAAA, 0, 0, 0, 0);
    cycle();
    check_eq("addr_wrap", imemAddr, 32'h0);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] bt_t;
      logic [31:0] j_t;
      bt_t = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      j_t  = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      drive(($urandom_range(49) == 0), ($urandom_range(99) < 70), ($urandom_range(99) < 60),
            $urandom, ($urandom_range(9) == 0), bt_t, ($urandom_range(9) == 0), j_t);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
